// File: rtl/rv_regfile_pkg.sv
// Shared register-file write types and default sizing for the write arbiter and its buffer.
package rv_regfile_pkg;

    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_STARVE_LIMIT = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_req_t;

endpackage

// File: rtl/reg_write_fifo.sv
// Circular buffer of pending long-latency-unit register writes, with a lookup
// that reports whether any buffered entry targets a given source register.
module reg_write_fifo
    import rv_regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  wr_req_t                  i_pushReq,
    input  logic                     i_pop,
    input  logic [4:0]               i_rs1,
    input  logic [4:0]               i_rs2,
    output wr_req_t                  o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_match1,
    output logic                     o_match2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wr_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    // Storage carries no reset; only the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wrPtr] <= i_pushReq;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PTR_W-1:0] offset;
        o_match1 = 1'b0;
        o_match2 = 1'b0;
        offset   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - r_rdPtr;
            if (CNT_W'(offset) < r_count) begin
                if ((i_rs1 != 5'd0) && (r_mem[i].rd == i_rs1)) begin
                    o_match1 = 1'b1;
                end
                if ((i_rs2 != 5'd0) && (r_mem[i].rd == i_rs2)) begin
                    o_match2 = 1'b1;
                end
            end
        end
    end

    assign o_head  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates the WB-stage write and buffered LLU writes onto one register-file write port.
// Optional starvation guard enabled by defining REG_WRITE_ARB_STARVE_EN.
module reg_write_arbiter
    import rv_regfile_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    input  logic                     llu_valid,
    input  logic [4:0]               llu_rd,
    input  logic [31:0]              llu_data,
    output logic                     llu_ready,
    output logic                     regWr,
    output logic [4:0]               ws,
    output logic [31:0]              wr_data,
    output logic                     wb_stall,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     hazard_rs1,
    output logic                     hazard_rs2,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_badParam
        $error("reg_write_arbiter: DEPTH must be a power of 2 in 2..16 and STARVE_LIMIT >= 1");
    end

    wr_req_t w_lluReq;
    wr_req_t w_head;
    logic    w_fifoEmpty;
    logic    w_push;
    logic    w_wbWrite;
    logic    w_forceDrain;
    logic    w_grantWb;
    logic    w_grantFifo;
    logic    w_match1;
    logic    w_match2;

    assign w_lluReq  = '{rd: llu_rd, data: llu_data};
    assign llu_ready = (fifo_count < CNT_W'(DEPTH));
    assign w_push    = llu_valid && llu_ready && (llu_rd != 5'd0);
    assign w_wbWrite = wb_valid && (wb_rd != 5'd0);

`ifdef REG_WRITE_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starveCnt;
    logic                r_force;

    assign w_forceDrain = r_force && !w_fifoEmpty;
    assign wb_stall     = w_forceDrain && w_wbWrite;

    // Counts back-to-back WB wins that left buffered writes waiting; the forced drain resets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starveCnt <= '0;
            r_force     <= 1'b0;
        end else if (w_forceDrain) begin
            r_starveCnt <= '0;
            r_force     <= 1'b0;
        end else if (w_grantWb && !w_fifoEmpty) begin
            r_starveCnt <= r_starveCnt + STARVE_W'(1);
            if (r_starveCnt == STARVE_W'(STARVE_LIMIT - 1)) begin
                r_force <= 1'b1;
            end
        end else begin
            r_starveCnt <= '0;
        end
    end
`else
    assign w_forceDrain = 1'b0;
    assign wb_stall     = 1'b0;
`endif

    assign w_grantWb   = w_wbWrite && !w_forceDrain;
    assign w_grantFifo = !w_grantWb && !w_fifoEmpty;

    reg_write_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_pushReq (w_lluReq),
        .i_pop     (w_grantFifo),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .o_head    (w_head),
        .o_count   (fifo_count),
        .o_empty   (w_fifoEmpty),
        .o_match1  (w_match1),
        .o_match2  (w_match2)
    );

    // ws/wr_data hold their last value on idle cycles; only regWr marks a live write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWr   <= 1'b0;
            ws      <= 5'd0;
            wr_data <= 32'd0;
        end else if (w_grantWb) begin
            regWr   <= 1'b1;
            ws      <= wb_rd;
            wr_data <= wb_data;
        end else if (w_grantFifo) begin
            regWr   <= 1'b1;
            ws      <= w_head.rd;
            wr_data <= w_head.data;
        end else begin
            regWr   <= 1'b0;
        end
    end

    assign hazard_rs1 = ((rs1 != 5'd0) && regWr && (ws == rs1)) || w_match1;
    assign hazard_rs2 = ((rs2 != 5'd0) && regWr && (ws == rs2)) || w_match2;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Table-driven bench for reg_write_arbiter: each vector checks combinational outputs
// before the edge and queues registered expectations checked one cycle later.
module tb_reg_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        llu_valid;
    logic [4:0]  llu_rd;
    logic [31:0] llu_data;
    logic        llu_ready;
    logic        regWr;
    logic [4:0]  ws;
    logic [31:0] wr_data;
    logic        wb_stall;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .DEPTH        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .llu_valid  (llu_valid),
        .llu_rd     (llu_rd),
        .llu_data   (llu_data),
        .llu_ready  (llu_ready),
        .regWr      (regWr),
        .ws         (ws),
        .wr_data    (wr_data),
        .wb_stall   (wb_stall),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard_rs1 (hazard_rs1),
        .hazard_rs2 (hazard_rs2),
        .fifo_count (fifo_count)
    );

    typedef struct {
        logic        wbValid;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        logic        lluValid;
        logic [4:0]  lluRd;
        logic [31:0] lluData;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        expReady;
        logic        expStall;
        logic        expHaz1;
        logic        expHaz2;
        logic        expRegWr;
        logic [4:0]  expWs;
        logic [31:0] expData;
        logic [2:0]  expCount;
    } vec_t;

    typedef struct {
        logic        regWr;
        logic [4:0]  ws;
        logic [31:0] data;
        logic [2:0]  count;
        string       tag;
    } exp_t;

    exp_t sbQ[$];
    vec_t table_q[$];
    int   errorCount = 0;
    int   checkCount = 0;

    function automatic vec_t mkVec(
        input logic wv, input logic [4:0] wrd, input logic [31:0] wdat,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
        input logic [4:0] r1, input logic [4:0] r2,
        input logic rdy, input logic stl, input logic h1, input logic h2,
        input logic ew, input logic [4:0] ews, input logic [31:0] edat, input logic [2:0] ecnt);
        vec_t v;
        v.wbValid = wv;  v.wbRd = wrd;  v.wbData = wdat;
        v.lluValid = lv; v.lluRd = lrd; v.lluData = ldat;
        v.rs1 = r1; v.rs2 = r2;
        v.expReady = rdy; v.expStall = stl; v.expHaz1 = h1; v.expHaz2 = h2;
        v.expRegWr = ew; v.expWs = ews; v.expData = edat; v.expCount = ecnt;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL scoreboard: no expectation queued for this cycle");
            return;
        end
        e = sbQ.pop_front();
        checkValue({e.tag, ".regWr"}, 32'(regWr), 32'(e.regWr));
        if (e.regWr) begin
            checkValue({e.tag, ".ws"}, 32'(ws), 32'(e.ws));
            checkValue({e.tag, ".wr_data"}, wr_data, e.data);
        end
        checkValue({e.tag, ".fifo_count"}, 32'(fifo_count), 32'(e.count));
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        wb_valid  = v.wbValid;  wb_rd  = v.wbRd;  wb_data  = v.wbData;
        llu_valid = v.lluValid; llu_rd = v.lluRd; llu_data = v.lluData;
        rs1 = v.rs1; rs2 = v.rs2;
        #1;
        checkValue({tag, ".llu_ready"}, 32'(llu_ready), 32'(v.expReady));
        checkValue({tag, ".wb_stall"}, 32'(wb_stall), 32'(v.expStall));
        checkValue({tag, ".hazard_rs1"}, 32'(hazard_rs1), 32'(v.expHaz1));
        checkValue({tag, ".hazard_rs2"}, 32'(hazard_rs2), 32'(v.expHaz2));
        e.regWr = v.expRegWr; e.ws = v.expWs; e.data = v.expData; e.count = v.expCount; e.tag = tag;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        llu_valid = 1'b0; llu_rd = '0; llu_data = '0;
        rs1 = '0; rs2 = '0;

        // Basic WB/LLU vectors, same-rd ordering and push+pop on the same cycle.
        table_q.push_back(mkVec(1, 5, 32'hA5, 0, 0, 0,      0, 0,  1,0,0,0, 1, 5, 32'hA5, 0));
        table_q.push_back(mkVec(0, 0, 0,      0, 0, 0,      5, 0,  1,0,1,0, 0, 0, 0,      0));
        table_q.push_back(mkVec(0, 0, 0,      1, 7, 32'h11, 7, 0,  1,0,0,0, 0, 0, 0,      1));
        table_q.push_back(mkVec(0, 0, 0,      0, 0, 0,      7, 0,  1,0,1,0, 1, 7, 32'h11, 0));
        table_q.push_back(mkVec(0, 0, 0,      0, 0, 0,      0, 7,  1,0,0,1, 0, 0, 0,      0));
        table_q.push_back(mkVec(0, 0, 0,      1, 0, 32'h55, 0, 0,  1,0,0,0, 0, 0, 0,      0));
        table_q.push_back(mkVec(1, 0, 32'h66, 0, 0, 0,      0, 0,  1,0,0,0, 0, 0, 0,      0));
        table_q.push_back(mkVec(1, 3, 32'h33, 1, 9, 32'h99, 0, 0,  1,0,0,0, 1, 3, 32'h33, 1));
        table_q.push_back(mkVec(1, 4, 32'h44, 1, 9, 32'h9A, 9, 0,  1,0,1,0, 1, 4, 32'h44, 2));
        table_q.push_back(mkVec(0, 0, 0,      0, 0, 0,      0, 4,  1,0,0,1, 1, 9, 32'h99, 1));
        table_q.push_back(mkVec(0, 0, 0,      1,10, 32'hAA, 0, 0,  1,0,0,0, 1, 9, 32'h9A, 1));
        table_q.push_back(mkVec(0, 0, 0,      0, 0, 0,      0, 0,  1,0,0,0, 1,10, 32'hAA, 0));
        table_q.push_back(mkVec(0, 0, 0,      0, 0, 0,      0, 0,  1,0,0,0, 0, 0, 0,      0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkValue("reset.regWr", 32'(regWr), 32'd0);
        checkValue("reset.ws", 32'(ws), 32'd0);
        checkValue("reset.wr_data", wr_data, 32'd0);
        checkValue("reset.fifo_count", 32'(fifo_count), 32'd0);
        checkValue("reset.llu_ready", 32'(llu_ready), 32'd1);
        checkValue("reset.wb_stall", 32'(wb_stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i], $sformatf("vec%0d", i));
        end

        // Fill the buffer behind a busy WB stage; the fifth LLU write waits for a pop.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mkVec(1, 5'(k + 1), 32'h100 + k, 1, 5'(20 + k), 32'h200 + k, 0, 0,
                                1,0,0,0, 1, 5'(k + 1), 32'h100 + k, 3'(k + 1)),
                          $sformatf("full%0d", k));
        end
        applyStimulus(mkVec(1, 5, 32'h105, 1, 24, 32'h204, 0, 0,  0,0,0,0, 1, 5, 32'h105, 4), "full4");
        applyStimulus(mkVec(0, 0, 0,       1, 24, 32'h204, 0, 0,  0,0,0,0, 1,20, 32'h200, 3), "full5");
        applyStimulus(mkVec(0, 0, 0,       1, 24, 32'h204, 0, 0,  1,0,0,0, 1,21, 32'h201, 3), "full6");
        applyStimulus(mkVec(0, 0, 0,       0, 0, 0,       23, 0,  1,0,1,0, 1,22, 32'h202, 2), "full7");
        applyStimulus(mkVec(0, 0, 0,       0, 0, 0,        0, 0,  1,0,0,0, 1,23, 32'h203, 1), "full8");
        applyStimulus(mkVec(0, 0, 0,       0, 0, 0,        0, 0,  1,0,0,0, 1,24, 32'h204, 0), "full9");
        applyStimulus(mkVec(0, 0, 0,       0, 0, 0,        0, 0,  1,0,0,0, 0, 0, 0,       0), "full10");

        // One buffered write behind a long run of WB writes.
        applyStimulus(mkVec(1, 1, 32'h1001, 1, 30, 32'h300, 0, 0,  1,0,0,0, 1, 1, 32'h1001, 1), "starve0");
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(mkVec(1, 5'(k + 1), 32'h1001 + k, 0, 0, 0, 0, 0,
                                1,0,0,0, 1, 5'(k + 1), 32'h1001 + k, 1),
                          $sformatf("starve%0d", k));
        end
`ifdef REG_WRITE_ARB_STARVE_EN
        applyStimulus(mkVec(1,10, 32'h100A, 0, 0, 0, 0, 0,  1,1,0,0, 1,30, 32'h300,  0), "starve9");
        applyStimulus(mkVec(1,10, 32'h100A, 0, 0, 0, 0, 0,  1,0,0,0, 1,10, 32'h100A, 0), "starve10");
        applyStimulus(mkVec(0, 0, 0,        0, 0, 0, 0, 0,  1,0,0,0, 0, 0, 0,        0), "starve11");
`else
        applyStimulus(mkVec(1,10, 32'h100A, 0, 0, 0, 0, 0,  1,0,0,0, 1,10, 32'h100A, 1), "starve9");
        applyStimulus(mkVec(0, 0, 0,        0, 0, 0, 0, 0,  1,0,0,0, 1,30, 32'h300,  0), "starve10");
        applyStimulus(mkVec(0, 0, 0,        0, 0, 0, 0, 0,  1,0,0,0, 0, 0, 0,        0), "starve11");
`endif

        // Reset with three buffered writes: they must vanish and never issue.
        applyStimulus(mkVec(1, 1, 32'h111, 1, 11, 32'hB1, 0, 0,  1,0,0,0, 1, 1, 32'h111, 1), "rst0");
        applyStimulus(mkVec(1, 2, 32'h112, 1, 12, 32'hB2, 0, 0,  1,0,0,0, 1, 2, 32'h112, 2), "rst1");
        applyStimulus(mkVec(1, 3, 32'h113, 1, 13, 32'hB3, 0, 0,  1,0,0,0, 1, 3, 32'h113, 3), "rst2");
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h116;
        llu_valid = 1'b0; rs1 = 5'd11; rs2 = 5'd3;
        reset = 1'b1;
        #1;
        checkValue("midReset.fifo_count", 32'(fifo_count), 32'd0);
        checkValue("midReset.regWr", 32'(regWr), 32'd0);
        checkValue("midReset.llu_ready", 32'(llu_ready), 32'd1);
        checkValue("midReset.wb_stall", 32'(wb_stall), 32'd0);
        checkValue("midReset.hazard_rs1", 32'(hazard_rs1), 32'd0);
        checkValue("midReset.hazard_rs2", 32'(hazard_rs2), 32'd0);
        @(negedge clk);
        wb_valid = 1'b0;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0,  1,0,0,0, 0, 0, 0, 0),
                          $sformatf("postReset%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
